// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: bus request, odd-parity frame on device clocks, ACK check.
// Define PS2_TX_CLK_FILTER_EN to add a glitch filter on the synchronized PS/2 clock.
module ps2_host_tx #(
    parameter int INHIBIT_CLKS   = 5000,
    parameter int INHIBIT_BITS   = 13,
    parameter int REQ_SETUP_CLKS = 16,
    parameter int TIMEOUT_CLKS   = 750000,
    parameter int TIMEOUT_BITS   = 20,
    parameter int FILTER_CLKS    = 8
) (
    input  logic       sys_clk_0,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    if (FILTER_CLKS < 1) begin : g_filter_check
        $error("FILTER_CLKS must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACKWAIT,
        S_RELEASE
    } state_t;

    state_t                  state;
    logic                    clk_meta;
    logic                    clk_sync;
    logic                    data_meta;
    logic                    data_sync;
    logic                    clk_filt;
    logic                    clk_filt_d;
    logic                    clk_fall;
    logic [7:0]              shift_data;
    logic                    parity;
    logic [3:0]              edge_cnt;
    logic [INHIBIT_BITS-1:0] phase_cnt;
    logic [TIMEOUT_BITS-1:0] wd_cnt;
    logic                    ack_err_flag;
    logic                    wd_active;
    logic                    wd_expired;

    always_ff @(posedge sys_clk_0 or negedge reset) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_in;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

`ifdef PS2_TX_CLK_FILTER_EN
    localparam int FILT_W = $clog2(FILTER_CLKS + 1);
    logic [FILT_W-1:0] filt_cnt;

    // Output follows the input only after it has disagreed for a full run of samples.
    always_ff @(posedge sys_clk_0 or negedge reset) begin
        if (!reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_W'(FILTER_CLKS)) begin
            clk_filt <= clk_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge sys_clk_0 or negedge reset) begin
        if (!reset) begin
            clk_filt <= 1'b1;
        end else begin
            clk_filt <= clk_sync;
        end
    end
`endif

    always_ff @(posedge sys_clk_0 or negedge reset) begin
        if (!reset) begin
            clk_filt_d <= 1'b1;
        end else begin
            clk_filt_d <= clk_filt;
        end
    end

    assign clk_fall   = clk_filt_d & ~clk_filt;
    assign wd_active  = (state == S_SHIFT) || (state == S_ACKWAIT) || (state == S_RELEASE);
    assign wd_expired = wd_active && !clk_fall &&
                        (wd_cnt == TIMEOUT_BITS'(TIMEOUT_CLKS - 1));
    assign rx_inhibit = tx_busy;

    // tx_ready/tx_busy lag the state by one cycle on completion so the done/timeout pulse
    // is still seen as part of the busy window.
    always_ff @(posedge sys_clk_0 or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            tx_ready     <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            tx_ack_err   <= 1'b0;
            tx_timeout   <= 1'b0;
            ps2_clk_oe   <= 1'b0;
            ps2_data_oe  <= 1'b0;
            shift_data   <= '0;
            parity       <= 1'b0;
            edge_cnt     <= '0;
            phase_cnt    <= '0;
            wd_cnt       <= '0;
            ack_err_flag <= 1'b0;
        end else begin
            tx_done    <= 1'b0;
            tx_ack_err <= 1'b0;
            tx_timeout <= 1'b0;

            if (wd_active) begin
                wd_cnt <= clk_fall ? '0 : wd_cnt + 1'b1;
            end

            if (wd_expired) begin
                state       <= S_IDLE;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_timeout  <= 1'b1;
                wd_cnt      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!tx_ready) begin
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                        end else if (tx_valid) begin
                            shift_data   <= tx_data;
                            parity       <= ~^tx_data;
                            edge_cnt     <= '0;
                            phase_cnt    <= '0;
                            ack_err_flag <= 1'b0;
                            tx_ready     <= 1'b0;
                            tx_busy      <= 1'b1;
                            ps2_clk_oe   <= 1'b1;
                            ps2_data_oe  <= 1'b0;
                            state        <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (phase_cnt == INHIBIT_BITS'(INHIBIT_CLKS - 1)) begin
                            phase_cnt   <= '0;
                            ps2_data_oe <= 1'b1;
                            state       <= S_REQ;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (phase_cnt == INHIBIT_BITS'(REQ_SETUP_CLKS - 1)) begin
                            phase_cnt  <= '0;
                            ps2_clk_oe <= 1'b0;
                            wd_cnt     <= '0;
                            state      <= S_SHIFT;
                        end else begin
                            phase_cnt <= phase_cnt + 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        // Start bit is already on the line; each falling edge presents the next bit.
                        if (clk_fall) begin
                            edge_cnt <= edge_cnt + 1'b1;
                            if (edge_cnt < 4'd8) begin
                                ps2_data_oe <= ~shift_data[edge_cnt[2:0]];
                            end else if (edge_cnt == 4'd8) begin
                                ps2_data_oe <= ~parity;
                            end else begin
                                ps2_data_oe <= 1'b0;
                                state       <= S_ACKWAIT;
                            end
                        end
                    end
                    S_ACKWAIT: begin
                        if (clk_fall) begin
                            edge_cnt     <= edge_cnt + 1'b1;
                            ack_err_flag <= data_sync;
                            state        <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        if (clk_sync && data_sync) begin
                            tx_done    <= 1'b1;
                            tx_ack_err <= ack_err_flag;
                            state      <= S_IDLE;
                        end
                    end
                    default: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector PS/2 device model clocks frames out of the host and
// compares each received bit, acknowledge result, watchdog abort and reset behaviour.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 40;
    localparam int REQ  = 16;
    localparam int TMO  = 100;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, tx_ack_err, tx_timeout, rx_inhibit;
    logic       clk_oe, data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       bus_clk, bus_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int to_cnt = 0;

    assign bus_clk  = ~(clk_oe | dev_clk_low);
    assign bus_data = ~(data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CLKS  (INH),
        .INHIBIT_BITS  (13),
        .REQ_SETUP_CLKS(REQ),
        .TIMEOUT_CLKS  (TMO),
        .TIMEOUT_BITS  (20),
        .FILTER_CLKS   (8)
    ) dut (
        .sys_clk_0  (clk),
        .reset      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_ack_err (tx_ack_err),
        .tx_timeout (tx_timeout),
        .rx_inhibit (rx_inhibit),
        .ps2_clk_in (bus_clk),
        .ps2_data_in(bus_data),
        .ps2_clk_oe (clk_oe),
        .ps2_data_oe(data_oe)
    );

    always @(posedge clk) begin
        if (tx_done)    done_cnt++;
        if (tx_timeout) to_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "bench time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line levels on device rising edges 1..10: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = b[i];
            if (b[i]) ones++;
        end
        f[8] = (ones % 2 == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic launch(input logic [7:0] b, input string tag);
        int c;
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~b;
        check({tag, "_clk_oe_after_accept"}, clk_oe, 1);
        check({tag, "_busy_after_accept"}, {tx_busy, rx_inhibit, tx_ready}, 3'b110);
        c = 0;
        while (data_oe !== 1'b1 && c < INH + 50) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_data_oe_rise_cycle"}, c, INH);
        while (clk_oe !== 1'b0 && c < INH + REQ + 50) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_clk_oe_fall_cycle"}, c, INH + REQ);
    endtask

    task automatic device_frame(input logic [7:0] b, input bit ack, input bit poke, input string tag);
        logic [9:0] exp_bits;
        logic [9:0] got;
        int d0;
        int t;
        exp_bits = frame_bits(b);
        d0 = done_cnt;
        check({tag, "_start_bit"}, bus_data, 0);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            got[i] = bus_data;
            dev_clk_low = 1'b0;
            if (poke && i == 3) begin
                tx_data  = 8'h00;
                tx_valid = 1'b1;
            end
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (HALF - 1) @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("%s_edge%0d", tag, i + 1), got[i], exp_bits[i]);
        end
        if (ack) dev_data_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        t = 0;
        while (tx_done !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_seen"}, tx_done, 1);
        check({tag, "_ack_err"}, tx_ack_err, !ack);
        check({tag, "_busy_in_done"}, tx_busy, 1);
        @(negedge clk);
        check({tag, "_ready_after"}, {tx_ready, tx_busy}, 2'b10);
        check({tag, "_oe_after"}, {clk_oe, data_oe}, 2'b00);
        check({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rack;
        int         t;
        int         d0;

        repeat (3) @(negedge clk);
        check("reset_ready_busy_inh", {tx_ready, tx_busy, rx_inhibit}, 3'b100);
        check("reset_pulses", {tx_done, tx_ack_err, tx_timeout}, 3'b000);
        check("reset_oe", {clk_oe, data_oe}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        launch(8'hED, "ed");
        device_frame(8'hED, 1'b1, 1'b0, "ed");
        launch(8'hF4, "f4");
        device_frame(8'hF4, 1'b1, 1'b0, "f4");
        launch(8'hFF, "ff");
        device_frame(8'hFF, 1'b0, 1'b0, "ff_nack");
        @(negedge clk);
        launch(8'hED, "poke");
        device_frame(8'hED, 1'b1, 1'b1, "poke");

        for (int r = 0; r < 3; r++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = 1'($urandom_range(0, 1));
            launch(rb, $sformatf("rnd%0d", r));
            device_frame(rb, rack, 1'b0, $sformatf("rnd%0d", r));
        end

        // Device never clocks: watchdog must abort.
        d0 = done_cnt;
        launch(8'hA5, "tmo");
        t = 0;
        while (tx_timeout !== 1'b1 && t < 3 * TMO) begin
            @(negedge clk);
            t++;
        end
        check("tmo_latency", t, TMO);
        check("tmo_busy_in_pulse", tx_busy, 1);
        check("tmo_oe", {clk_oe, data_oe}, 2'b00);
        @(negedge clk);
        check("tmo_ready_after", {tx_ready, tx_busy}, 2'b10);
        check("tmo_no_done", done_cnt - d0, 0);
        check("tmo_pulse_count", to_cnt, 1);

        // Asynchronous reset after edge 5 while the host drives data low.
        launch(8'hE5, "rst");
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i < 4) begin
                dev_clk_low = 1'b0;
                repeat (HALF) @(negedge clk);
            end
        end
        check("rst_pre_data_oe", data_oe, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_oe", {clk_oe, data_oe}, 2'b00);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_after_ready_busy", {tx_ready, tx_busy, rx_inhibit}, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (LED set 0xED, enable 0xF4, reset 0xFF, …) to the keyboard on the same open-collector clock/data pair used by the keyboard receive path. It runs the bus-request sequence, shifts the byte out on device-generated clocks with odd parity, and checks the device acknowledge. It also drives `rx_inhibit` so the receive path ignores bus activity while a transmission is in progress.

## Interface
- `INHIBIT_CLKS`, 5000: `sys_clk_0` cycles that clock is held low before the request (100 µs at 50 MHz).
- `INHIBIT_BITS`, 13: width of the inhibit counter.
- `REQ_SETUP_CLKS`, 16: cycles that data and clock are both low before clock is released.
- `TIMEOUT_CLKS`, 750000: watchdog limit between device clock edges (15 ms).
- `TIMEOUT_BITS`, 20: width of the watchdog counter.
- `FILTER_CLKS`, 8: stable-sample count for the clock glitch filter.

Ports:
- `sys_clk_0`  in  1: system clock, 50 MHz.
- `reset`  in  1: asynchronous, active-low reset.
- `tx_data`  in  8: byte to send, captured on accept.
- `tx_valid`  in  1: request to send.
- `tx_ready`  out  1: high in IDLE; the transfer is accepted when `tx_valid & tx_ready`.
- `tx_busy`  out  1: high in any state other than IDLE.
- `tx_done`  out  1: one-cycle pulse when a transfer ends normally.
- `tx_ack_err`  out  1: valid with `tx_done`; 1 = device did not acknowledge.
- `tx_timeout`  out  1: one-cycle pulse when the watchdog aborts a transfer.
- `rx_inhibit`  out  1: equals `tx_busy`; the receive path discards frames while it is high.
- `ps2_clk_in`  in  1: raw PS/2 clock pin.
- `ps2_data_in`  in  1: raw PS/2 data pin.
- `ps2_clk_oe`  out  1: 1 pulls PS/2 clock low, 0 releases it.
- `ps2_data_oe`  out  1: 1 pulls PS/2 data low, 0 releases it.

## Operation
- `ps2_clk_in` and `ps2_data_in` each pass through a 2-flop synchronizer.
- A falling edge is the registered filtered clock going from 1 to 0.
- States are IDLE, INHIBIT, REQ, SHIFT, ACKWAIT, RELEASE.
- **IDLE**: both `oe` low. On accept, latch `tx_data`, compute parity = ~^data, and go to INHIBIT.
- **INHIBIT**: `ps2_clk_oe`=1, `ps2_data_oe`=0 for INHIBIT_CLKS cycles, then go to REQ.
- **REQ**: `ps2_clk_oe`=1, `ps2_data_oe`=1 for REQ_SETUP_CLKS cycles, then go to SHIFT. The watchdog is cleared on leaving REQ.
- **SHIFT**: `ps2_clk_oe`=0. The start bit (data low) is held from REQ. A 4-bit edge counter `k` starts at 0 and counts falling edges:
  - edges 1–8: `ps2_data_oe` = ~data[k-1], LSB first.
  - edge 9: `ps2_data_oe` = ~parity.
  - edge 10: `ps2_data_oe`=0 (stop bit); go to ACKWAIT.
- **ACKWAIT**: on the next falling edge (11), sample synchronized data. 0 means ACK, 1 sets the error flag. Go to RELEASE.
- **RELEASE**: wait until synchronized clock and data are both 1, then pulse `tx_done` with `tx_ack_err` = flag, and go to IDLE.
- **Watchdog** (SHIFT, ACKWAIT, RELEASE): the counter clears on every falling edge. At TIMEOUT_CLKS-1 it aborts: both `oe` are 0 next cycle, `tx_timeout` pulses, state goes to IDLE, and `tx_done` does not pulse.
- `tx_valid` while busy is ignored; it is not queued.
- `tx_data` changes after accept have no effect.

## Timing
- Reset values:
  - state IDLE, `tx_ready`=1, `tx_busy`=0, `rx_inhibit`=0.
  - `tx_done`, `tx_ack_err`, `tx_timeout` = 0.
  - both `oe` = 0, all counters 0.
- Reset assertion at any point releases both lines asynchronously.
- Accept cycle N: `ps2_clk_oe`=1 and `tx_busy`=1 from cycle N+1.
- `ps2_data_oe` rises at N+1+INHIBIT_CLKS.
- `ps2_clk_oe` falls at N+1+INHIBIT_CLKS+REQ_SETUP_CLKS.
- Pin falling edge to `ps2_data_oe` update: 3 cycles without the filter; 3+FILTER_CLKS cycles with it. Both are well inside the ~30 µs clock-low half period.
- `tx_done`/`tx_timeout` cycle: `tx_busy` is still 1. `tx_ready`=1 from the next cycle.
- A new accept is possible in the cycle after `tx_done`.

## Configuration
- `PS2_TX_CLK_FILTER_EN` defined:
  - The synchronized clock feeds a filter that changes its output only after FILTER_CLKS consecutive equal samples.
  - Edge detection uses the filtered clock.
- `PS2_TX_CLK_FILTER_EN` undefined:
  - Edge detection uses the synchronized clock directly.
  - The filter logic and FILTER_CLKS are unused.

## Test plan
- Send 0xED with a device model that ACKs:
  - data bits 1,0,1,1,0,1,1,1 on edges 1–8.
  - parity 1 on edge 9, line released on edge 10.
  - `tx_done` pulse with `tx_ack_err`=0.
- Send 0xF4: parity bit on edge 9 = 0; `tx_done`, `tx_ack_err`=0.
- Send 0xFF with the device holding data high on edge 11: `tx_done` with `tx_ack_err`=1; both `oe` = 0 afterwards.
- Device never clocks after REQ (small TIMEOUT_CLKS=100 in bench): `tx_timeout` pulse at exactly 100 cycles after clock release; no `tx_done`; `tx_ready`=1 next cycle.
- Pulse `tx_valid` with 0x00 during SHIFT of 0xED: ignored; 0xED frame unchanged; exactly one `tx_done`.
- Assert `reset` low after edge 5: both `oe` = 0 immediately; after release, `tx_ready`=1 and `tx_busy`=0.
